mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_req_latch.sv | 35 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory port arbiter.
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '0;

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// One-entry request holding register with a valid bit. A capture while the
// entry is occupied is dropped; the owner must wait for its response.
module arb_req_latch
    import mem_arb_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     capture_i,
    input  logic     clear_i,
    input  mem_req_t req_i,
    output logic     valid_o,
    output mem_req_t req_o
);

    logic     valid_q;
    mem_req_t req_q;

    // Load on capture into an empty slot, free the slot once served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            req_q   <= MEM_REQ_IDLE;
        end else if (capture_i && !valid_q) begin
            valid_q <= 1'b1;
            req_q   <= req_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            req_q   <= MEM_REQ_IDLE;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data.
// Data wins by default; a starvation counter forces fetch after
// STARVE_LIMIT data grants taken while a fetch was waiting.
module mem_port_arbiter
    import mem_arb_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    mem_req_t    mem_q;
    logic        i_resp_q, d_resp_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    logic        i_vld, d_vld;
    mem_req_t    i_req, d_req;
    mem_req_t    i_req_in, d_req_in;
    logic        i_grant, d_grant, done;

    // Fetch is read-only; a data write masks off any concurrent read mask.
    assign i_req_in = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    assign d_req_in = '{addr:  dmem_addr,
                        rmask: (|dmem_wmask) ? 4'h0 : dmem_rmask,
                        wmask: dmem_wmask,
                        wdata: dmem_wdata};

    arb_req_latch u_i_latch (
        .clk       (clk),
        .rst       (rst),
        .capture_i (|imem_rmask),
        .clear_i   (done && (state_q == I_BUSY)),
        .req_i     (i_req_in),
        .valid_o   (i_vld),
        .req_o     (i_req)
    );

    arb_req_latch u_d_latch (
        .clk       (clk),
        .rst       (rst),
        .capture_i (|(dmem_rmask | dmem_wmask)),
        .clear_i   (done && (state_q == D_BUSY)),
        .req_i     (d_req_in),
        .valid_o   (d_vld),
        .req_o     (d_req)
    );

    // Arbitration in IDLE, completion detection while busy.
    always_comb begin
        state_d = state_q;
        i_grant = 1'b0;
        d_grant = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_vld && !(i_vld && (starve_q == LIMIT))) begin
                    d_grant = 1'b1;
                    state_d = D_BUSY;
                end else if (i_vld) begin
                    i_grant = 1'b1;
                    state_d = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count data grants that jumped a waiting fetch, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!i_vld || i_grant) begin
            starve_d = 4'd0;
        end else if (d_grant && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Downstream request is loaded on grant and held until the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= MEM_REQ_IDLE;
        end else if (i_grant) begin
            mem_q <= i_req;
        end else if (d_grant) begin
            mem_q <= d_req;
        end else if (done) begin
            mem_q <= MEM_REQ_IDLE;
        end
    end

    // One-cycle response pulse and read data back to whoever owned the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            i_resp_q <= done && (state_q == I_BUSY);
            d_resp_q <= done && (state_q == D_BUSY);
            if (done && (state_q == I_BUSY)) begin
                i_rdata_q <= mem_rdata;
            end
            if (done && (state_q == D_BUSY)) begin
                d_rdata_q <= (|mem_q.wmask) ? 32'h0 : mem_rdata;
            end
        end
    end

    assign mem_addr   = mem_q.addr;
    assign mem_rmask  = mem_q.rmask;
    assign mem_wmask  = mem_q.wmask;
    assign mem_wdata  = mem_q.wdata;
    assign imem_resp  = i_resp_q;
    assign imem_rdata = i_rdata_q;
    assign dmem_resp  = d_resp_q;
    assign dmem_rdata = d_rdata_q;

endmodule
